// File: rtl/dem_pkg.sv
// Shared types and helpers for the DEM-DAC tree verification path.
package dem_pkg;

    typedef struct packed {
        logic dir;
        logic parity;
        logic cons;
    } err_flags_t;

    localparam int unsigned ERR_DIR  = 2;
    localparam int unsigned ERR_PAR  = 1;
    localparam int unsigned ERR_CONS = 0;
    localparam int unsigned ERR_W    = 3;

    // Largest legal parent code for a node of the given width: 2^(width-1)-1.
    function automatic logic [31:0] max_code(input int unsigned width);
        return (32'd1 << (width - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/dem_err_counter.sv
// Saturating flagged-sample counter with sticky flag; clear wins over increment.
module dem_err_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sticky_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_o    <= '0;
            sticky_o <= 1'b0;
        end else if (clr_i) begin
            cnt_o    <= '0;
            sticky_o <= 1'b0;
        end else if (inc_i) begin
            sticky_o <= 1'b1;
            if (cnt_o != CNT_MAX) begin
                cnt_o <= cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switching_merge_block.sv
// Inverse DEM switching node: rebuilds parent code and switching magnitude
// from a child pair and flags conservation, parity and PN-direction errors.
module switching_merge_block
    import dem_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  x1_i,
    input  logic [WIDTH-1:0]  x2_i,
    input  logic              pn_seq_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  x_o,
    output logic [WIDTH-1:0]  s_o,
    output logic [ERR_W-1:0]  err_o,
    output logic              err_sticky_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    input  logic              clr_i
);

    localparam int unsigned      SUM_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX_X = WIDTH'(max_code(WIDTH));

    logic             s1_valid;
    logic [SUM_W-1:0] s1_sum;
    logic [SUM_W-1:0] s1_diff;
    logic             s1_pn;
    logic             s1_advance;
    logic             err_inc;

    logic [SUM_W-1:0] diff_abs_c;
    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] s_c;
    err_flags_t       flags_c;

    // Stage 1 may move whenever stage 2 is empty or draining this cycle.
    assign s1_advance = !valid_o || ready_i;
    assign ready_o    = !s1_valid || s1_advance;
    assign err_inc    = valid_o && ready_i && (err_o != '0);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_diff  <= '0;
            s1_pn    <= 1'b0;
        end else if (ready_o) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_sum  <= SUM_W'(x1_i) + SUM_W'(x2_i);
                s1_diff <= SUM_W'(x1_i) - SUM_W'(x2_i);
                s1_pn   <= pn_seq_i;
            end
        end
    end

    // Sum and diff share parity, so both halvings drop the same LSB.
    always_comb begin
        diff_abs_c     = s1_diff[SUM_W-1] ? (-s1_diff) : s1_diff;
        x_c            = s1_sum[SUM_W-1:1];
        s_c            = diff_abs_c[SUM_W-1:1];
        flags_c        = '0;
        flags_c.cons   = s1_sum[0] || (x_c > MAX_X);
        flags_c.parity = s_c[0] != x_c[0];
        flags_c.dir    = (s1_diff != '0) && (s1_diff[SUM_W-1] == s1_pn);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_o <= 1'b0;
            x_o     <= '0;
            s_o     <= '0;
            err_o   <= '0;
        end else if (s1_advance) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                x_o   <= x_c;
                s_o   <= s_c;
                err_o <= flags_c;
            end
        end
    end

    dem_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .inc_i    (err_inc),
        .clr_i    (clr_i),
        .cnt_o    (err_cnt_o),
        .sticky_o (err_sticky_o)
    );

endmodule

// File: tb/tb_switching_merge_block.sv
// Bench for switching_merge_block: directed and random pairs against a queue-based reference.
module tb_switching_merge_block;
    import dem_pkg::*;

    localparam int unsigned W = 8;
    localparam int MAXC = (1 << (W - 1)) - 1;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] s;
        logic [2:0]   e;
        int           acc;
    } item_t;

    logic         clk_i, reset_ni, valid_i, pn_seq_i, ready_i, clr_i;
    logic [W-1:0] x1_i, x2_i;
    logic         ready_o, valid_o, err_sticky_o;
    logic [W-1:0] x_o, s_o;
    logic [2:0]   err_o;
    logic [15:0]  err_cnt_o;
    logic         ready_o2, valid_o2, sticky2;
    logic [W-1:0] x_o2, s_o2;
    logic [2:0]   err_o2;
    logic [1:0]   cnt2;

    switching_merge_block #(.WIDTH(W), .CNT_W(16)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
        .x1_i(x1_i), .x2_i(x2_i), .pn_seq_i(pn_seq_i), .valid_o(valid_o),
        .ready_i(ready_i), .x_o(x_o), .s_o(s_o), .err_o(err_o),
        .err_sticky_o(err_sticky_o), .err_cnt_o(err_cnt_o), .clr_i(clr_i)
    );

    switching_merge_block #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o2),
        .x1_i(x1_i), .x2_i(x2_i), .pn_seq_i(pn_seq_i), .valid_o(valid_o2),
        .ready_i(ready_i), .x_o(x_o2), .s_o(s_o2), .err_o(err_o2),
        .err_sticky_o(sticky2), .err_cnt_o(cnt2), .clr_i(clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    cyc = 0;
    int    m_cnt16 = 0;
    int    m_cnt2 = 0;
    bit    m_sticky = 0;
    item_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: parent/magnitude and flags straight from the merge rules.
    function automatic item_t model(input int a, input int b, input logic p);
        item_t it;
        int sum, d, x, s;
        sum = a + b;
        d   = a - b;
        x   = sum / 2;
        s   = ((d < 0) ? -d : d) / 2;
        it.x = W'(x);
        it.s = W'(s);
        it.e = '0;
        it.e[ERR_CONS] = (sum % 2 == 1) || (x > MAXC);
        it.e[ERR_PAR]  = (s % 2) != (x % 2);
        it.e[ERR_DIR]  = (d > 0 && !p) || (d < 0 && p);
        it.acc = 0;
        return it;
    endfunction

    // One clock: drive, check pre-edge outputs vs model, advance model.
    task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic p, input logic rdy, input logic clr, output logic acc);
        logic exp_vo, exp_ro, emit;
        item_t it;
        valid_i = v; x1_i = a; x2_i = b; pn_seq_i = p; ready_i = rdy; clr_i = clr;
        #1;
        exp_vo = (q.size() > 0) && (cyc >= q[0].acc + 1);
        exp_ro = (q.size() < 2) || rdy;
        chk("valid_o", 32'(valid_o), 32'(exp_vo));
        chk("ready_o", 32'(ready_o), 32'(exp_ro));
        chk("valid_o_sat", 32'(valid_o2), 32'(exp_vo));
        chk("ready_o_sat", 32'(ready_o2), 32'(exp_ro));
        if (exp_vo) begin
            chk("x_o", 32'(x_o), 32'(q[0].x));
            chk("s_o", 32'(s_o), 32'(q[0].s));
            chk("err_o", 32'(err_o), 32'(q[0].e));
            chk("x_o_sat", 32'(x_o2), 32'(q[0].x));
            chk("s_o_sat", 32'(s_o2), 32'(q[0].s));
            chk("err_o_sat", 32'(err_o2), 32'(q[0].e));
        end
        chk("err_cnt_o", 32'(err_cnt_o), 32'(m_cnt16));
        chk("err_sticky_o", 32'(err_sticky_o), 32'(m_sticky));
        chk("err_cnt_sat", 32'(cnt2), 32'(m_cnt2));
        chk("err_sticky_sat", 32'(sticky2), 32'(m_sticky));
        acc  = v && exp_ro;
        emit = exp_vo && rdy;
        if (clr) begin
            m_cnt16 = 0; m_cnt2 = 0; m_sticky = 0;
        end else if (emit && q[0].e != 3'b000) begin
            m_sticky = 1;
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (emit) void'(q.pop_front());
        if (acc) begin
            it = model(int'(a), int'(b), p);
            it.acc = cyc + 1;
            q.push_back(it);
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic idle(input int n, input logic rdy);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, rdy, 1'b0, acc);
    endtask

    initial begin
        logic         acc;
        int           idx;
        logic [W-1:0] bpa [5];
        logic [W-1:0] bpb [5];
        logic         bpp [5];
        logic [W-1:0] ra, rb;
        logic         rp, rv, rr, rc;
        int           x, s;

        reset_ni = 1'b0; valid_i = 1'b0; x1_i = '0; x2_i = '0;
        pn_seq_i = 1'b0; ready_i = 1'b1; clr_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_x_o", 32'(x_o), 32'd0);
        chk("rst_s_o", 32'(s_o), 32'd0);
        chk("rst_err_o", 32'(err_o), 32'd0);
        chk("rst_sticky", 32'(err_sticky_o), 32'd0);
        chk("rst_cnt", 32'(err_cnt_o), 32'd0);
        reset_ni = 1'b1;
        @(negedge clk_i);

        // Directed pairs at full throughput.
        tick(1'b1, 8'd13, 8'd7, 1'b1, 1'b1, 1'b0, acc);
        tick(1'b1, 8'd7, 8'd13, 1'b1, 1'b1, 1'b0, acc);
        tick(1'b1, 8'd8, 8'd7, 1'b1, 1'b1, 1'b0, acc);
        tick(1'b1, 8'd120, 8'd120, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'd200, 8'd200, 1'b0, 1'b1, 1'b0, acc);
        tick(1'b1, 8'd12, 8'd8, 1'b1, 1'b1, 1'b0, acc);
        tick(1'b1, 8'd255, 8'd0, 1'b1, 1'b1, 1'b0, acc);
        idle(3, 1'b1);

        // Back-pressure: five samples, ready_i low for four cycles.
        bpa = '{8'd20, 8'd3, 8'd100, 8'd64, 8'd9};
        bpb = '{8'd10, 8'd5, 8'd90, 8'd64, 8'd1};
        bpp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0;
        for (int t = 0; t < 4; t++) begin
            tick(1'b1, bpa[idx], bpb[idx], bpp[idx], 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        valid_i = 1'b1; ready_i = 1'b0;
        #1;
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        for (int t = 0; t < 20 && idx < 5; t++) begin
            tick(1'b1, bpa[idx], bpb[idx], bpp[idx], 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'd5);
        idle(3, 1'b1);

        // Saturation of the 2-bit counter, then clear racing a sixth error.
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 6; i++) tick(1'b1, 8'd7, 8'd13, 1'b1, 1'b1, 1'b0, acc);
        idle(1, 1'b1);
        chk("sat_cnt2", 32'(cnt2), 32'd3);
        chk("sat_cnt16", 32'(err_cnt_o), 32'd5);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, acc);
        chk("clr_cnt2", 32'(cnt2), 32'd0);
        chk("clr_cnt16", 32'(err_cnt_o), 32'd0);
        chk("clr_sticky", 32'(err_sticky_o), 32'd0);
        idle(2, 1'b1);

        // Random traffic; half the pairs are built from a legal parent.
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            rc = ($urandom_range(0, 31) == 0);
            rp = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                x = $urandom_range(0, MAXC);
                s = $urandom_range(0, x);
                if ((s % 2) != (x % 2)) s = (s > 0) ? s - 1 : 1;
                ra = rp ? W'(x + s) : W'(x - s);
                rb = rp ? W'(x - s) : W'(x + s);
            end else begin
                ra = W'($urandom_range(0, 255));
                rb = W'($urandom_range(0, 255));
            end
            tick(rv, ra, rb, rp, rr, rc, acc);
        end
        idle(4, 1'b1);

        // Reset with two samples in flight.
        tick(1'b1, 8'd30, 8'd10, 1'b1, 1'b0, 1'b0, acc);
        tick(1'b1, 8'd40, 8'd20, 1'b1, 1'b0, 1'b0, acc);
        #2 reset_ni = 1'b0;
        #1;
        chk("midrst_valid_o", 32'(valid_o), 32'd0);
        chk("midrst_x_o", 32'(x_o), 32'd0);
        chk("midrst_cnt", 32'(err_cnt_o), 32'd0);
        q.delete();
        m_cnt16 = 0; m_cnt2 = 0; m_sticky = 0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        idle(5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
